// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters, with a
// one-entry registered result stage. Define ALU_ARB_FIXED_PRIO_EN for strict lowest-index priority.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int OP_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*XLEN-1:0]   req_op1,
    input  logic [NUM_REQ*XLEN-1:0]   req_op2,
    output logic [OP_W-1:0]           alu_operation,
    output logic [XLEN-1:0]           alu_op1,
    output logic [XLEN-1:0]           alu_op2,
    input  logic [XLEN-1:0]           alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [XLEN-1:0]           rsp_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]    rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]    rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               gnt_any;
    logic [ID_W:0]      sum;
    logic [ID_W-1:0]    idx;
    logic               can_accept;
    logic               accept;

    assign can_accept = !rsp_valid_q || rsp_ready;
    assign accept     = gnt_any && can_accept;

    // Search from rr_ptr upward, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        gnt_any  = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!gnt_any && req_valid[idx]) begin
                gnt_any  = 1'b1;
                grant_id = idx;
            end
        end
        if (gnt_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = can_accept ? grant : '0;

    // Idle requesters never reach the ALU: inputs stay at zero without a grant.
    always_comb begin
        alu_operation = '0;
        alu_op1       = '0;
        alu_op2       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_operation = req_op[i*OP_W +: OP_W];
                alu_op1       = req_op1[i*XLEN +: XLEN];
                alu_op2       = req_op2[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_result;
            rsp_id_d    = grant_id;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    // Priority rotates only on an actual transfer, to just past the winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (int'(grant_id) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (NUM_REQ=3): a high-level model predicts grants and
// results, expected responses are queued and a separate monitor checks each response transfer.
module tb_alu_arbiter;

    localparam int N    = 3;
    localparam int XLEN = 32;
    localparam int OP_W = 4;
    localparam int ID_W = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*OP_W-1:0]   req_op;
    logic [N*XLEN-1:0]   req_op1;
    logic [N*XLEN-1:0]   req_op2;
    logic [OP_W-1:0]     alu_operation;
    logic [XLEN-1:0]     alu_op1;
    logic [XLEN-1:0]     alu_op2;
    logic [XLEN-1:0]     alu_result;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_data;
    logic [ID_W-1:0]     rsp_id;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
        .alu_operation(alu_operation), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    function automatic logic [XLEN-1:0] alu_fn(input logic [OP_W-1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return {a[15:0], b[15:0]} ^ {28'd0, op};
        endcase
    endfunction

    assign alu_result = alu_fn(alu_operation, alu_op1, alu_op2);

    // Requester-side model state and arbiter model state
    bit                  v[N];
    logic [OP_W-1:0]     m_op[N];
    logic [XLEN-1:0]     m_a[N];
    logic [XLEN-1:0]     m_b[N];
    int                  m_ptr;
    bit                  m_full;
    logic [ID_W+XLEN-1:0] exp_q[$];
    int                  n_chk = 0;
    int                  n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive_cycle(input bit rdy);
        int  g;
        int  idx;
        bit  can;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_valid[i]               = v[i];
            req_op[i*OP_W +: OP_W]     = m_op[i];
            req_op1[i*XLEN +: XLEN]    = m_a[i];
            req_op2[i*XLEN +: XLEN]    = m_b[i];
        end
        rsp_ready = rdy;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        can = !m_full || rdy;
        exp_rdy = (g >= 0 && can) ? N'(1 << g) : '0;
        chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (g < 0) begin
            chk("alu_idle", 64'(alu_op1 | alu_op2 | XLEN'(alu_operation)), 64'd0);
        end else if (can) begin
            chk("alu_op1", 64'(alu_op1), 64'(m_a[g]));
            chk("alu_op2", 64'(alu_op2), 64'(m_b[g]));
        end
        if (g >= 0 && can) begin
            exp_q.push_back({ID_W'(g), alu_fn(m_op[g], m_a[g], m_b[g])});
            m_full = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            m_ptr = (g + 1) % N;
`endif
            v[g] = 1'b0;
        end else if (rdy) begin
            m_full = 1'b0;
        end
    endtask

    task automatic rand_reqs(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(99) < pct) begin
                v[i]    = 1'b1;
                m_op[i] = OP_W'($urandom_range(0, 7));
                m_a[i]  = $urandom;
                m_b[i]  = $urandom;
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        m_full = 1'b0;
        m_ptr  = 0;
        exp_q.delete();
    endtask

    // Monitor: every response transfer must match the head of the expectation queue
    initial begin
        logic [ID_W+XLEN-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", 64'({rsp_id, rsp_data}), 64'(e));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_op1   = '0;
        req_op2   = '0;
        rsp_ready = 1'b0;
        clear_model();
        for (int i = 0; i < N; i++) begin
            m_op[i] = '0; m_a[i] = '0; m_b[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: ADD 5 + 7
        v[0] = 1'b1; m_op[0] = 4'd0; m_a[0] = 32'd5; m_b[0] = 32'd7;
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        chk("single_data", 64'(rsp_data), 64'd12);
        chk("single_id", 64'(rsp_id), 64'd0);

        // Full contention, no stall
        for (int c = 0; c < 12; c++) begin
            rand_reqs(100);
            drive_cycle(1'b1);
        end

        // Backpressure for 3 cycles, then release
        for (int c = 0; c < 3; c++) begin
            rand_reqs(100);
            drive_cycle(1'b0);
        end
        rand_reqs(100);
        drive_cycle(1'b1);

        // Wrap: drain, then only requester 2, then 0 and 2
        for (int c = 0; c < 6; c++) drive_cycle(1'b1);
        v[2] = 1'b1; m_op[2] = 4'd1; m_a[2] = 32'd100; m_b[2] = 32'd1;
        drive_cycle(1'b1);
        v[0] = 1'b1; m_op[0] = 4'd4; m_a[0] = 32'hF0F0; m_b[0] = 32'h0FF0;
        v[2] = 1'b1; m_op[2] = 4'd3; m_a[2] = 32'h1;    m_b[2] = 32'h2;
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        drive_cycle(1'b1);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            rand_reqs(60);
            drive_cycle($urandom_range(99) < 70);
        end

        // Asynchronous reset while a result is stalled
        for (int c = 0; c < 3; c++) begin
            rand_reqs(100);
            drive_cycle(1'b0);
        end
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midreset_rsp_data", 64'(rsp_data), 64'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        rand_reqs(100);
        drive_cycle(1'b1);
        for (int c = 0; c < 6; c++) begin
            rand_reqs(100);
            drive_cycle(1'b1);
        end

        // Final drain
        for (int c = 0; c < 5; c++) drive_cycle(1'b1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
